// File: rtl/axil_cmd_master_if.sv
// AXI-Lite bus bundle between the command master and an AXI-Lite slave.
interface axil_cmd_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   m_aw_addr;
  logic [2:0]      m_aw_prot;
  logic            m_aw_valid;
  logic            m_aw_ready;
  logic [DW-1:0]   m_w_data;
  logic [DW/8-1:0] m_w_strb;
  logic            m_w_valid;
  logic            m_w_ready;
  logic [1:0]      m_b_resp;
  logic            m_b_valid;
  logic            m_b_ready;
  logic [AW-1:0]   m_ar_addr;
  logic [2:0]      m_ar_prot;
  logic            m_ar_valid;
  logic            m_ar_ready;
  logic [DW-1:0]   m_r_data;
  logic [1:0]      m_r_resp;
  logic            m_r_valid;
  logic            m_r_ready;

  modport master (
    output m_aw_addr, m_aw_prot, m_aw_valid, input m_aw_ready,
    output m_w_data, m_w_strb, m_w_valid, input m_w_ready,
    input m_b_resp, m_b_valid, output m_b_ready,
    output m_ar_addr, m_ar_prot, m_ar_valid, input m_ar_ready,
    input m_r_data, m_r_resp, m_r_valid, output m_r_ready
  );

  modport slave (
    input m_aw_addr, m_aw_prot, m_aw_valid, output m_aw_ready,
    input m_w_data, m_w_strb, m_w_valid, output m_w_ready,
    output m_b_resp, m_b_valid, input m_b_ready,
    input m_ar_addr, m_ar_prot, m_ar_valid, output m_ar_ready,
    output m_r_data, m_r_resp, m_r_valid, input m_r_ready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding command-to-AXI-Lite master: accepts one read or write
// command, runs it on the AXI-Lite bus and holds the response until consumed.
module axil_cmd_master #(
  parameter int AXI_LITE_AW = 32,
  parameter int AXI_LITE_DW = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_we_i,
  input  logic [AXI_LITE_AW-1:0]   cmd_addr_i,
  input  logic [AXI_LITE_DW-1:0]   cmd_wdata_i,
  input  logic [AXI_LITE_DW/8-1:0] cmd_wstrb_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [AXI_LITE_DW-1:0]   rsp_rdata_o,
  output logic [1:0]               rsp_resp_o,
  output logic [7:0]               err_cnt_o,
  axil_cmd_master_if.master        m_axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic                     aw_valid_q, aw_valid_d;
  logic                     w_valid_q, w_valid_d;
  logic                     ar_valid_q, ar_valid_d;
  logic                     b_ready_q, b_ready_d;
  logic                     r_ready_q, r_ready_d;
  logic [AXI_LITE_AW-1:0]   addr_q;
  logic [AXI_LITE_DW-1:0]   wdata_q;
  logic [AXI_LITE_DW/8-1:0] wstrb_q;
  logic [AXI_LITE_DW-1:0]   rdata_q;
  logic [1:0]               resp_q;
  logic [7:0]               err_q;

  logic cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_done, w_done, rsp_err;

  assign cmd_hs  = cmd_valid_i && cmd_ready_o;
  assign aw_hs   = aw_valid_q && m_axi.m_aw_ready;
  assign w_hs    = w_valid_q && m_axi.m_w_ready;
  assign ar_hs   = ar_valid_q && m_axi.m_ar_ready;
  assign b_hs    = b_ready_q && m_axi.m_b_valid;
  assign r_hs    = r_ready_q && m_axi.m_r_valid;
  // A channel counts as done once its beat has gone or is going this cycle.
  assign aw_done = !aw_valid_q || aw_hs;
  assign w_done  = !w_valid_q || w_hs;
  assign rsp_err = (b_hs && (m_axi.m_b_resp != 2'b00)) ||
                   (r_hs && (m_axi.m_r_resp != 2'b00));

  // State register and registered bus-side handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
    end
  end

  // Next-state decode; any unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs) state_d = cmd_we_i ? WR_AW_W : RD_AR;
      WR_AW_W: if (aw_done && w_done) state_d = WR_B;
      WR_B:    if (b_hs) state_d = RSP;
      RD_AR:   if (ar_hs) state_d = RD_R;
      RD_R:    if (r_hs) state_d = RSP;
      RSP:     if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: bus valids/readies are derived from the next state so that
  // they can never be left asserted by a state the FSM has already left.
  always_comb begin
    cmd_ready_o = rst_ni && (state_q == IDLE);
    rsp_valid_o = rst_ni && (state_q == RSP);
    aw_valid_d  = 1'b0;
    w_valid_d   = 1'b0;
    if (state_d == WR_AW_W) begin
      aw_valid_d = (state_q == WR_AW_W) ? (aw_valid_q && !m_axi.m_aw_ready) : 1'b1;
      w_valid_d  = (state_q == WR_AW_W) ? (w_valid_q && !m_axi.m_w_ready) : 1'b1;
    end
    ar_valid_d = (state_d == RD_AR);
    b_ready_d  = (state_d == WR_B);
    r_ready_d  = (state_d == RD_R);
  end

  // Command payload capture; held unchanged for the life of the transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cmd_hs) begin
      addr_q  <= cmd_addr_i;
      wdata_q <= cmd_we_i ? cmd_wdata_i : '0;
      wstrb_q <= cmd_we_i ? cmd_wstrb_i : '0;
    end
  end

  // Response capture and saturating error counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      resp_q  <= 2'b00;
      err_q   <= 8'd0;
    end else begin
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= m_axi.m_b_resp;
      end else if (r_hs) begin
        rdata_q <= m_axi.m_r_data;
        resp_q  <= m_axi.m_r_resp;
      end
      if (rsp_err && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign rsp_rdata_o      = rdata_q;
  assign rsp_resp_o       = resp_q;
  assign err_cnt_o        = err_q;
  assign m_axi.m_aw_addr  = addr_q;
  assign m_axi.m_aw_prot  = 3'b000;
  assign m_axi.m_aw_valid = aw_valid_q;
  assign m_axi.m_w_data   = wdata_q;
  assign m_axi.m_w_strb   = wstrb_q;
  assign m_axi.m_w_valid  = w_valid_q;
  assign m_axi.m_b_ready  = b_ready_q;
  assign m_axi.m_ar_addr  = addr_q;
  assign m_axi.m_ar_prot  = 3'b000;
  assign m_axi.m_ar_valid = ar_valid_q;
  assign m_axi.m_r_ready  = r_ready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a hand-scripted AXI-Lite slave.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;

  axil_cmd_master_if #(.AW(32), .DW(32)) bus ();

  axil_cmd_master #(.AXI_LITE_AW(32), .AXI_LITE_DW(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_wstrb_i (cmd_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_resp_o  (rsp_resp),
    .err_cnt_o   (err_cnt),
    .m_axi       (bus)
  );

  always #5 clk = ~clk;

  // Bus monitor: beat counters, activity counter and hold-stability checker.
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int          act_cnt = 0, stab_err = 0;
  logic        aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
  logic [31:0] aw_prev = '0, ar_prev = '0, w_prev = '0;
  logic [3:0]  s_prev = '0;

  always @(posedge clk) begin
    if (rst_ni) begin
      if (bus.m_aw_valid && bus.m_aw_ready) aw_cnt <= aw_cnt + 1;
      if (bus.m_w_valid && bus.m_w_ready)   w_cnt  <= w_cnt + 1;
      if (bus.m_ar_valid && bus.m_ar_ready) ar_cnt <= ar_cnt + 1;
      if (bus.m_b_valid && bus.m_b_ready)   b_cnt  <= b_cnt + 1;
      if (bus.m_r_valid && bus.m_r_ready)   r_cnt  <= r_cnt + 1;
      if (bus.m_aw_valid || bus.m_w_valid || bus.m_ar_valid) act_cnt <= act_cnt + 1;
      if ((aw_hold && (!bus.m_aw_valid || bus.m_aw_addr != aw_prev)) ||
          (w_hold && (!bus.m_w_valid || bus.m_w_data != w_prev || bus.m_w_strb != s_prev)) ||
          (ar_hold && (!bus.m_ar_valid || bus.m_ar_addr != ar_prev)))
        stab_err <= stab_err + 1;
    end
    aw_hold <= rst_ni && bus.m_aw_valid && !bus.m_aw_ready;
    w_hold  <= rst_ni && bus.m_w_valid && !bus.m_w_ready;
    ar_hold <= rst_ni && bus.m_ar_valid && !bus.m_ar_ready;
    aw_prev <= bus.m_aw_addr;
    ar_prev <= bus.m_ar_addr;
    w_prev  <= bus.m_w_data;
    s_prev  <= bus.m_w_strb;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'(1));
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 64'(rsp_valid), 64'(1));
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int a0, w0, b0, act0;

  initial begin
    rst_ni = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    bus.m_aw_ready = 1'b0; bus.m_w_ready = 1'b0; bus.m_ar_ready = 1'b0;
    bus.m_b_valid = 1'b0; bus.m_b_resp = 2'b00;
    bus.m_r_valid = 1'b0; bus.m_r_resp = 2'b00; bus.m_r_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_valids", 64'({bus.m_aw_valid, bus.m_w_valid, bus.m_ar_valid}), 64'(0));
    chk("rst_readies", 64'({bus.m_b_ready, bus.m_r_ready}), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    chk("rst_rsp_data", 64'({rsp_rdata, rsp_resp}), 64'(0));
    rst_ni = 1'b1;
    #1;
    chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));
    tick();

    // Write, zero-wait slave
    bus.m_aw_ready = 1'b1; bus.m_w_ready = 1'b1; bus.m_b_valid = 1'b1; bus.m_b_resp = 2'b00;
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    issue(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF);
    chk("wr_n1_valids", 64'({bus.m_aw_valid, bus.m_w_valid}), 64'(2'b11));
    chk("wr_n1_addr", 64'(bus.m_aw_addr), 64'(32'h0000_0010));
    chk("wr_n1_data", 64'({bus.m_w_data, bus.m_w_strb}), 64'({32'hA5A5_5A5A, 4'hF}));
    chk("wr_n1_prot", 64'({bus.m_aw_prot, bus.m_ar_prot}), 64'(0));
    chk("wr_n1_cmd_ready", 64'(cmd_ready), 64'(0));
    tick();
    chk("wr_n2_state", 64'({bus.m_aw_valid, bus.m_w_valid, bus.m_b_ready}), 64'(3'b001));
    chk("wr_n2_rsp_valid", 64'(rsp_valid), 64'(0));
    tick();
    chk("wr_n3_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("wr_n3_resp", 64'(rsp_resp), 64'(0));
    chk("wr_n3_rdata", 64'(rsp_rdata), 64'(0));
    chk("wr_beats", 64'({aw_cnt - a0, w_cnt - w0, b_cnt - b0}), 64'({32'd1, 32'd1, 32'd1}));
    bus.m_aw_ready = 1'b0; bus.m_w_ready = 1'b0; bus.m_b_valid = 1'b0;
    consume();
    chk("wr_done_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("wr_done_cmd_ready", 64'(cmd_ready), 64'(1));

    // Read, 3-cycle r_valid delay
    bus.m_ar_ready = 1'b1;
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    chk("rd_ar_valid", 64'(bus.m_ar_valid), 64'(1));
    chk("rd_ar_addr", 64'(bus.m_ar_addr), 64'(32'h0000_0020));
    tick();
    bus.m_ar_ready = 1'b0;
    chk("rd_r_ready", 64'({bus.m_ar_valid, bus.m_r_ready}), 64'(2'b01));
    repeat (3) begin
      tick();
      chk("rd_wait_rsp_valid", 64'(rsp_valid), 64'(0));
    end
    bus.m_r_valid = 1'b1; bus.m_r_data = 32'h1234_5678; bus.m_r_resp = 2'b00;
    tick();
    bus.m_r_valid = 1'b0; bus.m_r_data = 32'h0;
    chk("rd_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rd_rdata", 64'(rsp_rdata), 64'(32'h1234_5678));
    repeat (3) begin
      tick();
      chk("rd_hold", 64'({rsp_valid, rsp_rdata, rsp_resp}), 64'({1'b1, 32'h1234_5678, 2'b00}));
    end
    consume();
    chk("rd_done_rsp_valid", 64'(rsp_valid), 64'(0));

    // Write, W accepted two cycles before AW
    a0 = aw_cnt; w0 = w_cnt;
    issue(1'b1, 32'h0000_0030, 32'hDEAD_BEEF, 4'h3);
    bus.m_w_ready = 1'b1;
    tick();
    bus.m_w_ready = 1'b0;
    chk("ww_after_w", 64'({bus.m_aw_valid, bus.m_w_valid}), 64'(2'b10));
    tick();
    chk("ww_aw_held", 64'({bus.m_aw_valid, bus.m_w_valid, bus.m_b_ready}), 64'(3'b100));
    bus.m_aw_ready = 1'b1;
    tick();
    bus.m_aw_ready = 1'b0;
    chk("ww_in_wr_b", 64'({bus.m_aw_valid, bus.m_w_valid, bus.m_b_ready}), 64'(3'b001));
    bus.m_b_valid = 1'b1; bus.m_b_resp = 2'b00;
    tick();
    bus.m_b_valid = 1'b0;
    chk("ww_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("ww_beats", 64'({aw_cnt - a0, w_cnt - w0}), 64'({32'd1, 32'd1}));
    consume();

    // 256 reads answered SLVERR
    bus.m_ar_ready = 1'b1; bus.m_r_valid = 1'b1; bus.m_r_resp = 2'b10; bus.m_r_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 256; i++) begin
      issue(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0);
      wait_rsp("slverr_rsp_valid");
      chk("slverr_resp", 64'(rsp_resp), 64'(2'b10));
      if (i == 0) chk("slverr_first_cnt", 64'(err_cnt), 64'(1));
      if (i == 254) chk("slverr_cnt_255", 64'(err_cnt), 64'(255));
      consume();
    end
    chk("slverr_final_cnt", 64'(err_cnt), 64'(255));

    // Response back-pressure blocks a new command
    bus.m_r_resp = 2'b00; bus.m_r_data = 32'hCAFE_0001;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    wait_rsp("bp_rsp_valid");
    bus.m_ar_ready = 1'b0; bus.m_r_valid = 1'b0;
    chk("bp_rdata", 64'(rsp_rdata), 64'(32'hCAFE_0001));
    cmd_we = 1'b1; cmd_addr = 32'h0000_0040; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'h1;
    cmd_valid = 1'b1;
    act0 = act_cnt;
    repeat (5) begin
      tick();
      chk("bp_cmd_ready", 64'({cmd_ready, rsp_valid}), 64'(2'b01));
    end
    chk("bp_no_activity", 64'(act_cnt - act0), 64'(0));
    bus.m_aw_ready = 1'b1; bus.m_w_ready = 1'b1; bus.m_b_valid = 1'b1; bus.m_b_resp = 2'b00;
    consume();
    chk("bp_idle_cmd_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    chk("bp_new_aw", 64'({bus.m_aw_valid, bus.m_aw_addr}), 64'({1'b1, 32'h0000_0040}));
    wait_rsp("bp_new_rsp");
    bus.m_aw_ready = 1'b0; bus.m_w_ready = 1'b0; bus.m_b_valid = 1'b0;
    consume();

    // Reset pulsed while waiting in WR_B
    bus.m_aw_ready = 1'b1; bus.m_w_ready = 1'b1;
    issue(1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'hF);
    tick();
    bus.m_aw_ready = 1'b0; bus.m_w_ready = 1'b0;
    chk("rwb_in_wr_b", 64'(bus.m_b_ready), 64'(1));
    rst_ni = 1'b0;
    #1;
    chk("rwb_rst_ctrl", 64'({cmd_ready, rsp_valid, bus.m_aw_valid, bus.m_w_valid,
                             bus.m_ar_valid, bus.m_b_ready, bus.m_r_ready}), 64'(0));
    chk("rwb_rst_data", 64'({bus.m_aw_addr, bus.m_w_data}), 64'(0));
    chk("rwb_rst_err", 64'({err_cnt, rsp_resp}), 64'(0));
    bus.m_b_valid = 1'b1;
    repeat (2) tick();
    #2;
    rst_ni = 1'b1;
    #1;
    chk("rwb_rel_cmd_ready", 64'(cmd_ready), 64'(1));
    tick();
    bus.m_b_valid = 1'b0;
    chk("rwb_after_idle", 64'({cmd_ready, rsp_valid, bus.m_b_ready}), 64'(3'b100));
    tick();
    chk("rwb_no_rsp", 64'(rsp_valid), 64'(0));

    chk("hold_stability", 64'(stab_err), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter AXI_LITE_AW, default 32, meaning AXI-Lite address width.
REQ-002 SHALL have parameter AXI_LITE_DW, default 32, meaning AXI-Lite data width (32 or 64).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cmd_valid_i  input  1  command request.
REQ-006 SHALL have port cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
REQ-007 SHALL have port cmd_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr_i  input  AXI_LITE_AW  target address.
REQ-009 SHALL have port cmd_wdata_i  input  AXI_LITE_DW  write data.
REQ-010 SHALL have port cmd_wstrb_i  input  AXI_LITE_DW/8  write byte strobes.
REQ-011 SHALL have port rsp_valid_o  output  1  response available.
REQ-012 SHALL have port rsp_ready_i  input  1  response consumed when high together with rsp_valid_o.
REQ-013 SHALL have port rsp_rdata_o  output  AXI_LITE_DW  read data; 0 for writes.
REQ-014 SHALL have port rsp_resp_o  output  2  captured BRESP/RRESP.
REQ-015 SHALL have port err_cnt_o  output  8  saturating count of non-OKAY responses.
REQ-016 SHALL have AXI-Lite master ports m_aw_addr/m_aw_prot/m_aw_valid (out), m_aw_ready (in); m_w_data/m_w_strb/m_w_valid (out), m_w_ready (in); m_b_resp/m_b_valid (in), m_b_ready (out); m_ar_addr/m_ar_prot/m_ar_valid (out), m_ar_ready (in); m_r_data/m_r_resp/m_r_valid (in), m_r_ready (out); widths per AXI-Lite.

Function
REQ-017 SHALL implement states IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
REQ-018 SHALL drive cmd_ready_o = 1 only in IDLE; one outstanding transaction at most.
REQ-019 SHALL, on command handshake in cycle N, register addr/data/strb and enter WR_AW_W (we=1) or RD_AR (we=0); m_aw_valid/m_w_valid or m_ar_valid high from cycle N+1.
REQ-020 SHALL drive m_aw_prot = m_ar_prot = 3'b000; all master outputs registered.
REQ-021 SHALL, in WR_AW_W, track AW and W handshakes independently: each valid drops the cycle after its own handshake, in either order or simultaneously, and stays high until then.
REQ-022 SHALL enter WR_B the cycle after both AW and W have completed; m_b_ready = 1 only in WR_B.
REQ-023 SHALL, in RD_AR, hold m_ar_valid until m_ar_ready, then enter RD_R; m_r_ready = 1 only in RD_R.
REQ-024 SHALL, on B or R handshake, capture resp (and r_data for reads, 0 for writes) into rsp registers and enter RSP; rsp_valid_o high from next cycle.
REQ-025 SHALL hold rsp_valid_o and rsp data stable in RSP until rsp_ready_i, then return to IDLE (cmd_ready_o high next cycle).
REQ-026 SHALL give zero-wait-slave latency: write cmd accepted N -> rsp_valid_o N+3; read cmd accepted N -> rsp_valid_o N+3.
REQ-027 SHALL increment err_cnt_o by 1 on each captured resp != 2'b00, saturating at 255 with no wrap.
REQ-028 SHALL never assert a valid with its matching ready low from a stale state; an invalid state decodes to IDLE.
REQ-029 SHALL hold all AXI address/data outputs stable while the corresponding valid is high.

Reset
REQ-030 SHALL, while rst_ni = 0, force state IDLE, every valid/ready output 0, rsp_rdata_o 0, rsp_resp_o 0, err_cnt_o 0, address/data outputs 0.
REQ-031 SHALL, on reset mid-transaction, abandon the transaction with no response emitted; cmd_ready_o = 1 on the first cycle after release.

Verification
REQ-032 SHALL test write, zero-wait slave: addr 0x0000_0010, data 0xA5A5_5A5A, strb 0xF -> one AW and W beat, rsp_valid_o at N+3, rsp_resp_o 00, rsp_rdata_o 0.
REQ-033 SHALL test read, slave returns 0x1234_5678 with 3-cycle r_valid delay -> rsp_rdata_o 0x1234_5678 held until rsp_ready_i.
REQ-034 SHALL test write, slave gives w_ready 2 cycles before aw_ready -> w_valid drops after W beat, aw_valid held, exactly one of each beat.
REQ-035 SHALL test 256 reads answered SLVERR (10) -> err_cnt_o = 255 at end, no wrap; every rsp_resp_o = 10.
REQ-036 SHALL test rsp_ready_i held low 5 cycles, then a new cmd_valid_i -> cmd_ready_o stays 0 and no AXI activity until the response is consumed.
REQ-037 SHALL test rst_ni pulsed low while in WR_B -> all outputs 0 during reset, no rsp_valid_o, IDLE afterward.
